al_mode_ctrl: RTL and testbench

- Mode and alarm sequencer for the alarm clock.
- Sits between the button/tick sources and the 7-segment display driver.
- Owns the HH:MM time-of-day and alarm registers, and sequences set-mode entry from buttons.
- Compares time against the alarm and drives ringing, snooze and blink state; presents a BCD word for the display.

---
 rtl/al_pkg.sv | 38 +++
 rtl/bcd_mod_counter.sv | 58 +++++
 rtl/al_mode_ctrl.sv | 149 ++++++++++++++
 tb/tb_al_mode_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/al_pkg.sv
// Shared types and constants for the alarm-clock mode/alarm sequencer.
// Fields are two-digit BCD; the display word packs hours then minutes.
package al_pkg;

  localparam int BCD_W    = 4;
  localparam int FIELD_W  = 2 * BCD_W;
  localparam int DISP_W   = 4 * BCD_W;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_TH = 3'd1,
    ST_SET_TM = 3'd2,
    ST_SET_AH = 3'd3,
    ST_SET_AM = 3'd4
  } mode_e;

  typedef struct packed {
    logic [BCD_W-1:0] h_tens;
    logic [BCD_W-1:0] h_ones;
    logic [BCD_W-1:0] m_tens;
    logic [BCD_W-1:0] m_ones;
  } disp_t;

  localparam logic [3:0] BLINK_OFF = 4'b0000;
  localparam logic [3:0] BLINK_HRS = 4'b1100;
  localparam logic [3:0] BLINK_MIN = 4'b0011;

  function automatic logic [FIELD_W-1:0] to_bcd2(input int v);
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] o;
    t = BCD_W'(v / 10);
    o = BCD_W'(v % 10);
    return {t, o};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX_VAL -> 00; o_nxt is the value after this cycle.
// o_carry pulses combinationally on the increment that wraps.
module bcd_mod_counter
  import al_pkg::*;
#(
  parameter int MAX_VAL = MIN_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inc,
  input  logic               i_load,
  input  logic [FIELD_W-1:0] i_load_val,
  output logic [FIELD_W-1:0] o_val,
  output logic [FIELD_W-1:0] o_nxt,
  output logic               o_carry
);

  localparam logic [FIELD_W-1:0] MAX_BCD = to_bcd2(MAX_VAL);

  logic [FIELD_W-1:0] r_val;
  logic [FIELD_W-1:0] w_inc_val;
  logic [BCD_W-1:0]   w_tens;
  logic [BCD_W-1:0]   w_ones;
  logic               w_at_max;

  assign w_tens   = r_val[FIELD_W-1:BCD_W];
  assign w_ones   = r_val[BCD_W-1:0];
  assign w_at_max = (r_val == MAX_BCD);

  always_comb begin
    w_inc_val = r_val;
    if (w_at_max)
      w_inc_val = '0;
    else if (w_ones == 4'd9)
      w_inc_val = {w_tens + 4'd1, 4'd0};
    else
      w_inc_val = {w_tens, w_ones + 4'd1};
  end

  always_comb begin
    o_nxt = r_val;
    if (i_load)
      o_nxt = i_load_val;
    else if (i_inc)
      o_nxt = w_inc_val;
  end

  assign o_carry = i_inc & ~i_load & w_at_max;
  assign o_val   = r_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_val <= '0;
    else
      r_val <= o_nxt;
  end

endmodule

// File: rtl/al_mode_ctrl.sv
// Alarm-clock mode FSM, HH:MM time/alarm registers, ring/snooze sequencing.
// Field updates land one cycle after a pulse; disp_word follows one cycle later.
module al_mode_ctrl
  import al_pkg::*;
#(
  parameter int RING_MINUTES   = 2,
  parameter int SNOOZE_MINUTES = 9
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        min_tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_alarm,
  output logic [15:0] disp_word,
  output logic [3:0]  blink_an,
  output logic        alarm_en,
  output logic        ringing,
  output logic [2:0]  mode
);

  localparam logic [3:0] RING_LOAD   = 4'(RING_MINUTES);
  localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MINUTES);

  mode_e              r_mode;
  disp_t              r_disp;
  logic [3:0]         r_blink;
  logic               r_alarm_en;
  logic               r_ringing;
  logic [3:0]         r_ring_cnt;
  logic [3:0]         r_snz_cnt;

  logic [FIELD_W-1:0] w_th, w_tm, w_ah, w_am;
  logic [FIELD_W-1:0] w_th_nxt, w_tm_nxt, w_ah_nxt, w_am_nxt;
  logic               w_th_carry, w_tm_carry, w_ah_carry, w_am_carry;
  logic               w_inc_evt, w_tick_adv, w_enter_set, w_snoozing, w_match;
  logic               w_th_inc, w_tm_inc, w_ah_inc, w_am_inc;
  logic               w_unused;

  // Mode wins over a same-cycle increment.
  assign w_inc_evt   = btn_inc & ~btn_mode;
  assign w_tick_adv  = min_tick & (r_mode inside {ST_RUN, ST_SET_AH, ST_SET_AM});
  assign w_enter_set = btn_mode & (r_mode inside {ST_RUN, ST_SET_TH, ST_SET_TM, ST_SET_AH});
  assign w_snoozing  = (r_snz_cnt != 4'd0);

  // Minute carry only ripples from ticks; set-mode increments never carry.
  assign w_tm_inc = w_tick_adv | (w_inc_evt & (r_mode == ST_SET_TM));
  assign w_th_inc = (w_tick_adv & w_tm_carry) | (w_inc_evt & (r_mode == ST_SET_TH));
  assign w_ah_inc = w_inc_evt & (r_mode == ST_SET_AH);
  assign w_am_inc = w_inc_evt & (r_mode == ST_SET_AM);

  assign w_match = w_tick_adv & (r_mode == ST_RUN) & r_alarm_en &
                   ({w_th_nxt, w_tm_nxt} == {w_ah, w_am});

  assign w_unused = ^{w_th_carry, w_ah_carry, w_am_carry, w_ah_nxt, w_am_nxt};

  bcd_mod_counter #(.MAX_VAL(HOUR_MAX)) u_time_hr (
    .clk(mclk), .rst_n(rst), .i_inc(w_th_inc), .i_load(1'b0), .i_load_val('0),
    .o_val(w_th), .o_nxt(w_th_nxt), .o_carry(w_th_carry)
  );

  bcd_mod_counter #(.MAX_VAL(MIN_MAX)) u_time_min (
    .clk(mclk), .rst_n(rst), .i_inc(w_tm_inc), .i_load(1'b0), .i_load_val('0),
    .o_val(w_tm), .o_nxt(w_tm_nxt), .o_carry(w_tm_carry)
  );

  bcd_mod_counter #(.MAX_VAL(HOUR_MAX)) u_alarm_hr (
    .clk(mclk), .rst_n(rst), .i_inc(w_ah_inc), .i_load(1'b0), .i_load_val('0),
    .o_val(w_ah), .o_nxt(w_ah_nxt), .o_carry(w_ah_carry)
  );

  bcd_mod_counter #(.MAX_VAL(MIN_MAX)) u_alarm_min (
    .clk(mclk), .rst_n(rst), .i_inc(w_am_inc), .i_load(1'b0), .i_load_val('0),
    .o_val(w_am), .o_nxt(w_am_nxt), .o_carry(w_am_carry)
  );

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_mode     <= ST_RUN;
      r_blink    <= BLINK_OFF;
      r_disp     <= '0;
      r_alarm_en <= 1'b0;
      r_ringing  <= 1'b0;
      r_ring_cnt <= 4'd0;
      r_snz_cnt  <= 4'd0;
    end else begin
      r_disp <= (r_mode inside {ST_SET_AH, ST_SET_AM}) ? {w_ah, w_am} : {w_th, w_tm};

      case (r_mode)
        ST_RUN:    if (btn_mode) begin r_mode <= ST_SET_TH; r_blink <= BLINK_HRS; end
        ST_SET_TH: if (btn_mode) begin r_mode <= ST_SET_TM; r_blink <= BLINK_MIN; end
        ST_SET_TM: if (btn_mode) begin r_mode <= ST_SET_AH; r_blink <= BLINK_HRS; end
        ST_SET_AH: if (btn_mode) begin r_mode <= ST_SET_AM; r_blink <= BLINK_MIN; end
        ST_SET_AM: if (btn_mode) begin r_mode <= ST_RUN;    r_blink <= BLINK_OFF; end
        default: begin
          r_mode  <= ST_RUN;
          r_blink <= BLINK_OFF;
        end
      endcase

      // A toggle only happens with nothing ringing or snoozing, so disarming
      // never leaves ring/snooze state behind.
      if (btn_alarm && !r_ringing && !w_snoozing)
        r_alarm_en <= ~r_alarm_en;

      if (w_enter_set) begin
        r_ringing  <= 1'b0;
        r_ring_cnt <= 4'd0;
        r_snz_cnt  <= 4'd0;
      end else if (btn_alarm) begin
        if (r_ringing) begin
          r_ringing  <= 1'b0;
          r_ring_cnt <= 4'd0;
        end else if (w_snoozing) begin
          r_snz_cnt <= 4'd0;
        end
      end else if (w_inc_evt && r_ringing) begin
        r_ringing  <= 1'b0;
        r_ring_cnt <= 4'd0;
        r_snz_cnt  <= SNOOZE_LOAD;
      end else if (min_tick) begin
        if (r_ringing) begin
          if (r_ring_cnt <= 4'd1) begin
            r_ringing  <= 1'b0;
            r_ring_cnt <= 4'd0;
          end else begin
            r_ring_cnt <= r_ring_cnt - 4'd1;
          end
        end else if (w_snoozing) begin
          r_snz_cnt <= r_snz_cnt - 4'd1;
          if (r_snz_cnt == 4'd1) begin
            r_ringing  <= 1'b1;
            r_ring_cnt <= RING_LOAD;
          end
        end else if (w_match) begin
          r_ringing  <= 1'b1;
          r_ring_cnt <= RING_LOAD;
        end
      end
    end
  end

  assign disp_word = r_disp;
  assign blink_an  = r_blink;
  assign alarm_en  = r_alarm_en;
  assign ringing   = r_ringing;
  assign mode      = r_mode;

endmodule

// File: tb/tb_al_mode_ctrl.sv
// Directed bench for al_mode_ctrl: set-mode entry, time wrap, ring, snooze and reset.
module tb_al_mode_ctrl;

  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic        min_tick = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_alarm = 1'b0;
  logic [15:0] disp_word;
  logic [3:0]  blink_an;
  logic        alarm_en;
  logic        ringing;
  logic [2:0]  mode;

  int checks = 0;
  int errors = 0;

  al_mode_ctrl #(.RING_MINUTES(2), .SNOOZE_MINUTES(9)) dut (
    .mclk(mclk), .rst(rst), .min_tick(min_tick), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .btn_alarm(btn_alarm), .disp_word(disp_word),
    .blink_an(blink_an), .alarm_en(alarm_en), .ringing(ringing), .mode(mode)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on any combination of inputs, held across one rising edge.
  task automatic press(input logic m, input logic i, input logic a, input logic t);
    @(negedge mclk);
    btn_mode = m; btn_inc = i; btn_alarm = a; min_tick = t;
    @(negedge mclk);
    btn_mode = 0; btn_inc = 0; btn_alarm = 0; min_tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) press(0, 0, 0, 1);
  endtask

  task automatic modes(input int n);
    for (int k = 0; k < n; k++) press(1, 0, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(0, 1, 0, 0);
  endtask

  task automatic settle();
    repeat (2) @(negedge mclk);
  endtask

  task automatic do_reset();
    @(negedge mclk); rst = 0;
    @(negedge mclk); rst = 1;
    settle();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_disp", disp_word, 16'h0000);
    chk("rst_blink", {12'h0, blink_an}, 16'h0000);
    chk("rst_alarm_en", {15'h0, alarm_en}, 16'h0000);
    chk("rst_ringing", {15'h0, ringing}, 16'h0000);
    chk("rst_mode", {13'h0, mode}, 16'h0000);
    @(negedge mclk); rst = 1;
    settle();

    // Time advance and midnight wrap
    ticks(60);
    settle();
    chk("run_60_ticks", disp_word, 16'h0100);
    ticks(1380);
    settle();
    chk("run_wrap_2359", disp_word, 16'h0000);

    // Set time to 03:05; tick in SET_TM is discarded
    modes(1);
    incs(3);
    modes(1);
    settle();
    chk("set_tm_blink", {12'h0, blink_an}, 16'h0003);
    ticks(1);
    incs(5);
    modes(1);
    settle();
    chk("set_ah_mode", {13'h0, mode}, 16'h0003);
    chk("set_ah_blink", {12'h0, blink_an}, 16'h000c);
    chk("set_ah_disp_alarm", disp_word, 16'h0000);
    modes(2);
    settle();
    chk("back_run_mode", {13'h0, mode}, 16'h0000);
    chk("back_run_blink", {12'h0, blink_an}, 16'h0000);
    chk("back_run_time", disp_word, 16'h0305);

    // Alarm 00:02 rings after the second tick, auto-silences after two more
    do_reset();
    modes(4);
    incs(2);
    settle();
    chk("alarm_set_disp", disp_word, 16'h0002);
    modes(1);
    press(0, 0, 1, 0);
    chk("alarm_armed", {15'h0, alarm_en}, 16'h0001);
    ticks(1);
    chk("no_ring_0001", {15'h0, ringing}, 16'h0000);
    ticks(1);
    chk("ring_at_0002", {15'h0, ringing}, 16'h0001);
    ticks(1);
    chk("ring_after_1", {15'h0, ringing}, 16'h0001);
    ticks(1);
    chk("ring_auto_off", {15'h0, ringing}, 16'h0000);
    chk("auto_off_armed", {15'h0, alarm_en}, 16'h0001);

    // Move alarm to 00:05 (time now 00:04), ring, snooze, re-ring, silence
    modes(4);
    incs(3);
    modes(1);
    ticks(1);
    chk("ring_at_0005", {15'h0, ringing}, 16'h0001);
    press(0, 1, 0, 0);
    chk("snooze_quiet", {15'h0, ringing}, 16'h0000);
    ticks(8);
    chk("snooze_8_ticks", {15'h0, ringing}, 16'h0000);
    ticks(1);
    chk("snooze_reriing", {15'h0, ringing}, 16'h0001);
    press(0, 0, 1, 0);
    chk("silence_ring", {15'h0, ringing}, 16'h0000);
    chk("silence_armed", {15'h0, alarm_en}, 16'h0001);
    settle();
    chk("time_0014", disp_word, 16'h0014);

    // Alarm 00:15: ring, snooze, then cancel the snooze with btn_alarm
    modes(4);
    incs(10);
    modes(1);
    ticks(1);
    chk("ring_at_0015", {15'h0, ringing}, 16'h0001);
    press(0, 1, 0, 0);
    ticks(3);
    press(0, 0, 1, 0);
    chk("cancel_no_toggle", {15'h0, alarm_en}, 16'h0001);
    ticks(9);
    chk("cancel_no_rering", {15'h0, ringing}, 16'h0000);

    // Match created by btn_inc never rings
    do_reset();
    press(0, 0, 1, 0);
    chk("arm_after_reset", {15'h0, alarm_en}, 16'h0001);
    ticks(1);
    chk("no_ring_0001_b", {15'h0, ringing}, 16'h0000);
    modes(2);
    incs(59);
    settle();
    chk("set_tm_wrap_disp", disp_word, 16'h0000);
    chk("inc_match_quiet", {15'h0, ringing}, 16'h0000);
    modes(3);
    settle();
    chk("inc_match_run_quiet", {15'h0, ringing}, 16'h0000);

    // Mode and inc in the same cycle: mode wins, hours unchanged
    press(1, 1, 0, 0);
    settle();
    chk("mode_inc_mode", {13'h0, mode}, 16'h0001);
    chk("mode_inc_hours", disp_word, 16'h0000);

    // Asynchronous reset from SET_AM with alarm armed and alarm field non-zero
    modes(3);
    incs(3);
    settle();
    chk("pre_rst_disp", disp_word, 16'h0003);
    @(posedge mclk);
    #2 rst = 0;
    #1;
    chk("arst_disp", disp_word, 16'h0000);
    chk("arst_blink", {12'h0, blink_an}, 16'h0000);
    chk("arst_mode", {13'h0, mode}, 16'h0000);
    chk("arst_alarm_en", {15'h0, alarm_en}, 16'h0000);
    chk("arst_ringing", {15'h0, ringing}, 16'h0000);
    @(negedge mclk); rst = 1;
    settle();
    chk("post_rst_mode", {13'h0, mode}, 16'h0000);
    chk("post_rst_disp", disp_word, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
